// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU and its request arbiter.
// Holds operand width, ALU select codes and the arbiter FSM encoding.
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [1:0] SEL_ADD = 2'b00;
  localparam logic [1:0] SEL_SUB = 2'b01;
  localparam logic [1:0] SEL_AND = 2'b10;
  localparam logic [1:0] SEL_OR  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 4-bit ALU: ADD/SUB/AND/OR, zero latency, no flow control.
// Carry is the adder carry-out for ADD and the borrow for SUB.
module alu
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0] A,
  input  logic [ALU_W-1:0] B,
  input  logic [1:0]       Sel,
  output logic [ALU_W-1:0] Result,
  output logic             Carry
);

  always_comb begin
    Result = '0;
    Carry  = 1'b0;
    case (Sel)
      SEL_ADD: {Carry, Result} = {1'b0, A} + {1'b0, B};
      // Bit 4 of the 5-bit difference is set exactly when A < B.
      SEL_SUB: {Carry, Result} = {1'b0, A} - {1'b0, B};
      SEL_AND: Result = A & B;
      SEL_OR:  Result = A | B;
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_pick.sv
// Combinational round-robin picker: first valid index at or above rr_ptr, wrapping.
// Zero latency; grant_vld is low when no request is valid.
module alu_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            grant_vld,
  output logic [IDW-1:0]  grant_idx
);

  int             off;
  logic [IDW-1:0] idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    off       = 0;
    idx       = '0;
    for (int i = 0; i < NREQ; i++) begin
      off = int'(rr_ptr) + i;
      if (off >= NREQ) off = off - NREQ;
      idx = IDW'(off);
      if (!grant_vld && req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NREQ requesters; response 2 cycles after accept.
// One op in flight; no request accepted in EXEC/RESP; RESP holds while rsp_ready is low.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
  input  logic [2*NREQ-1:0]     req_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [ALU_W-1:0]      rsp_result,
  output logic                  rsp_carry,
  output logic                  busy
);

  state_t           state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ALU_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [1:0]       op_sel_q, op_sel_d;
  logic [IDW-1:0]   op_id_q, op_id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [ALU_W-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [ALU_W-1:0] alu_result;
  logic             alu_carry;

  logic [ALU_W-1:0] a_arr   [NREQ];
  logic [ALU_W-1:0] b_arr   [NREQ];
  logic [1:0]       sel_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign a_arr[i]   = req_a[ALU_W*i +: ALU_W];
    assign b_arr[i]   = req_b[ALU_W*i +: ALU_W];
    assign sel_arr[i] = req_sel[2*i +: 2];
  end

  alu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  alu u_alu (
    .A      (op_a_q),
    .B      (op_b_q),
    .Sel    (op_sel_q),
    .Result (alu_result),
    .Carry  (alu_carry)
  );

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && grant_vld) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    op_id_d      = op_id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          op_a_d   = a_arr[grant_idx];
          op_b_d   = b_arr[grant_idx];
          op_sel_d = sel_arr[grant_idx];
          op_id_d  = grant_idx;
          rr_ptr_d = (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + IDW'(1);
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_id_d     = op_id_q;
        rsp_result_d = alu_result;
        rsp_carry_d  = alu_carry;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      op_id_q      <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      op_id_q      <= op_id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_carry  = rsp_carry_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed ops, round-robin order, back-pressure, mid-op reset.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_sel;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_result;
  logic        rsp_carry, busy;

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  exp_q[$];
  logic [6:0]  mon_e;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake pops one expected {id,result,carry}.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d result=0x%0h carry=%0d, expected no response",
                   rsp_id, rsp_result, rsp_carry);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rsp_id_result_carry", {25'd0, rsp_id, rsp_result, rsp_carry}, {25'd0, mon_e});
        end
      end
    end
  end

  task automatic set_req(input int id, input logic [3:0] a, input logic [3:0] b, input logic [1:0] sel);
    req_a[4*id +: 4]   = a;
    req_b[4*id +: 4]   = b;
    req_sel[2*id +: 2] = sel;
  endtask

  // Called at posedge+1 while idle; returns at posedge+1 after the response handshake.
  task automatic issue(input int id, input logic [3:0] a, input logic [3:0] b,
                       input logic [1:0] sel, input logic [3:0] er, input logic ec);
    int lat;
    bit seen;
    set_req(id, a, b, sel);
    req_valid[id] = 1'b1;
    @(negedge clk);
    chk("ready_same_cycle", {28'd0, req_ready}, 32'(1) << id);
    exp_q.push_back({2'(id), er, ec});
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) seen = 1'b1;
    end
    chk("latency", 32'(lat), 32'd2);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, cyc, last, k;
    logic [6:0] snap;

    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid",  {31'd0, rsp_valid}, 0);
    chk("reset_rsp_id",     {30'd0, rsp_id}, 0);
    chk("reset_rsp_result", {28'd0, rsp_result}, 0);
    chk("reset_rsp_carry",  {31'd0, rsp_carry}, 0);
    chk("reset_busy",       {31'd0, busy}, 0);
    chk("reset_req_ready",  {28'd0, req_ready}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed ALU vectors; expected values worked by hand.
    issue(0, 4'b0011, 4'b0101, 2'b00, 4'b1000, 1'b0);
    issue(1, 4'b1111, 4'b0001, 2'b00, 4'b0000, 1'b1);
    issue(1, 4'b0010, 4'b0100, 2'b01, 4'b1110, 1'b1);
    issue(2, 4'b0110, 4'b0011, 2'b01, 4'b0011, 1'b0);
    issue(3, 4'b1010, 4'b1100, 2'b10, 4'b1000, 1'b0);
    issue(3, 4'b1010, 4'b1100, 2'b11, 4'b1110, 1'b0);

    // Round-robin with all requesters valid; pointer is back at 0 here.
    for (int i = 0; i < 4; i++) set_req(i, 4'(i + 1), 4'd2, 2'b00);
    req_valid = 4'hF;
    cyc  = 0;
    last = 0;
    k    = 0;
    while (k < 5 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_ready != 0) begin
        g = 0;
        for (int j = 0; j < 4; j++) if (req_ready[j]) g = j;
        chk("rr_onehot", 32'($countones(req_ready)), 1);
        chk("rr_order", 32'(g), 32'(k % 4));
        if (k > 0) chk("rr_spacing", 32'(cyc - last), 3);
        exp_q.push_back({2'(g), 4'(g + 3), 1'b0});
        last = cyc;
        k++;
      end
    end
    if (k < 5) chk("rr_grant_count", 32'(k), 5);
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();

    // Back-pressure: pointer is 1, so requester 2 wins over 3.
    rsp_ready = 1'b0;
    set_req(2, 4'b0101, 4'b1001, 2'b00);
    set_req(3, 4'b1001, 4'b1001, 2'b00);
    req_valid = 4'b1100;
    @(negedge clk);
    chk("bp_grant", {28'd0, req_ready}, 32'b0100);
    exp_q.push_back({2'd2, 4'b1110, 1'b0});
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    chk("exec_ready_zero", {28'd0, req_ready}, 0);
    @(negedge clk);
    chk("bp_rsp_valid", {31'd0, rsp_valid}, 1);
    snap = {rsp_id, rsp_result, rsp_carry};
    repeat (5) begin
      @(negedge clk);
      chk("bp_stable", {25'd0, rsp_id, rsp_result, rsp_carry}, {25'd0, snap});
      chk("bp_valid_held", {31'd0, rsp_valid}, 1);
      chk("bp_ready_zero", {28'd0, req_ready}, 0);
      chk("bp_busy", {31'd0, busy}, 1);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_grant", {28'd0, req_ready}, 32'b1000);
    exp_q.push_back({2'd3, 4'b0010, 1'b1});
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();

    // Mid-operation reset: grant requester 1 so the pointer moves to 2, then reset in EXEC.
    set_req(1, 4'b0111, 4'b0001, 2'b00);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("rst_pre_grant", {28'd0, req_ready}, 32'b0010);
    @(posedge clk);
    #1 req_valid = '0;
    chk("rst_exec_busy", {31'd0, busy}, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", {31'd0, busy}, 0);
    chk("rst_async_valid", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    chk("rst_rsp_result", {28'd0, rsp_result}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'd0, rsp_valid}, 0);
    end
    @(posedge clk);
    #1;
    req_a     = 16'h4321;
    req_b     = 16'h2222;
    req_sel   = 8'h00;
    req_valid = 4'hF;
    @(negedge clk);
    chk("rst_grant_req0", {28'd0, req_ready}, 32'b0001);
    exp_q.push_back({2'd0, 4'b0011, 1'b0});
    @(posedge clk);
    #1 req_valid = '0;
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
